gray_decoder: RTL and testbench
===============================

// Module: gray_decoder
// PURPOSE
//  Receive end of the 3-bit Gray count interface: samples a Gray-coded count
//  stream, decodes it to binary, checks every step is a legal +1 move, counts
//  wraps and flags a sticky overflow. Sits downstream of the Gray counter.
//  It monitors and decodes that counter's output.
// PARAMETERS
//  WIDTH   3  Gray/binary code width (>=2)
//  WRAP_W  4  width of wrap counter WrapCnt
// PORTS
//  Clk       in   1        system clock, all state on posedge
//  Reset     in   1        synchronous, active-high reset
//  Valid     in   1        GrayIn sampled this cycle
//  GrayIn    in   WIDTH    Gray-coded count
//  Binary    out  WIDTH    decoded count (registered)
//  Locked    out  1        1 while state==TRACK
//  StepErr   out  1        1-cycle pulse on illegal step
//  Overflow  out  1        sticky: set on first max->0 wrap
//  WrapCnt   out  WRAP_W   number of wraps, modulo 2^WRAP_W
// BEHAVIOUR
//  - Reset (sync, highest priority, beats Valid): state=IDLE, Binary=0,
//    last Gray=0, Locked=0, StepErr=0, Overflow=0, WrapCnt=0. Mid-run -> same.
//  - Latency: Valid at edge N -> Binary/StepErr/Overflow/WrapCnt valid after N.
//  - Valid=0: all registers hold; StepErr=0.
//  - FSM states IDLE, TRACK, FAULT:
//    IDLE  +Valid: capture GrayIn, Binary=decode(GrayIn), ->TRACK. No check.
//    TRACK +Valid: d = popcount(GrayIn ^ lastGray); nb = decode(GrayIn)
//      d==0       : no change, no error (repeat sample)
//      nb==Binary+1 (mod 2^WIDTH): accept; Binary=nb, lastGray=GrayIn
//        Binary==max & nb==0: WrapCnt+=1 (wraps to 0), Overflow<=1 (sticky)
//      otherwise  : StepErr=1 for one cycle, Binary/lastGray hold, ->FAULT
//    FAULT +Valid: resync as IDLE (capture, decode, ->TRACK), StepErr=0.
//  - Locked combinational from state register only.
//  - decode: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i]. All arithmetic mod 2^WIDTH.
//  - Overflow cleared only by Reset; WrapCnt never saturates.
// CONFIGURATION
//  GRAY_DECODER_DOWN_EN defined: nb==Binary-1 also accepted in TRACK;
//    Binary==0 & nb==max decrements WrapCnt (mod 2^WRAP_W); Overflow unchanged.
//  Undefined: a -1 step is an illegal step (StepErr, ->FAULT).
// STRUCTURE
//  - Package gray_pkg: FSM state encoding (IDLE/TRACK/FAULT, 2 bits),
//    WIDTH/WRAP_W defaults, max-code localparam.
//  - Sub-module gray_to_bin: combinational WIDTH-bit Gray->binary decoder,
//    instantiated for GrayIn. Top holds FSM, registers, step check.
// TESTING (WIDTH=3, WRAP_W=4)
//  1 Reset, then Valid on 000,001,011,010,110,111,101,100,000 -> Binary
//    0..7,0; Locked=1 from 1st; Overflow=1, WrapCnt=1 after 9th; no StepErr.
//  2 Locked at 001 (Binary=1), Valid GrayIn=110 -> StepErr pulse 1 cycle,
//    Binary stays 1, Locked=0; next Valid 110 -> Binary=4, Locked=1.
//  3 Valid=0 for 5 cycles with GrayIn toggling -> all outputs unchanged;
//    repeated Valid on same code 011 -> Binary=2, no StepErr.
//  4 Reset asserted with Valid=1 mid-count (Binary=5, Overflow=1) -> next
//    cycle Binary=0, Overflow=0, WrapCnt=0, Locked=0.
//  5 Locked at 011 (Binary=2), Valid 001 -> default: StepErr, FAULT;
//    with GRAY_DECODER_DOWN_EN: Binary=1, no StepErr; 000->100 -> WrapCnt-1.
//  6 17 full wraps -> WrapCnt wraps to 1, Overflow stays 1.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types and defaults for the Gray count receive path.
// Optional feature macro: GRAY_DECODER_DOWN_EN (accept -1 steps).
package gray_pkg;

   localparam int GRAY_WIDTH  = 3;
   localparam int GRAY_WRAP_W = 4;

   localparam logic [GRAY_WIDTH-1:0] GRAY_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_FAULT = 2'd2
   } gray_state_e;

endpackage

// File: rtl/gray_to_bin.sv
// Combinational WIDTH-bit Gray to binary decoder.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin
   import gray_pkg::*;
#(
   parameter int WIDTH = GRAY_WIDTH
) (
   input  logic [WIDTH-1:0] gray_i,
   output logic [WIDTH-1:0] bin_o
);

   logic [WIDTH-1:0] bin;

   always_comb begin
      bin            = '0;
      bin[WIDTH-1]   = gray_i[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray_i[i];
      end
   end

   assign bin_o = bin;

endmodule

// File: rtl/gray_decoder.sv
// Gray count monitor: decodes, checks +1 steps, counts wraps, sticky overflow.
// Optional feature macro: GRAY_DECODER_DOWN_EN (accept -1 steps).
module gray_decoder
   import gray_pkg::*;
#(
   parameter int WIDTH  = GRAY_WIDTH,
   parameter int WRAP_W = GRAY_WRAP_W
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Valid,
   input  logic [WIDTH-1:0]  GrayIn,
   output logic [WIDTH-1:0]  Binary,
   output logic              Locked,
   output logic              StepErr,
   output logic              Overflow,
   output logic [WRAP_W-1:0] WrapCnt
);

   localparam logic [WIDTH-1:0] MaxCode = '1;

   gray_state_e       state_q, state_d;
   logic [WIDTH-1:0]  bin_q, bin_d;
   logic [WIDTH-1:0]  gray_q, gray_d;
   logic              err_q, err_d;
   logic              ovf_q, ovf_d;
   logic [WRAP_W-1:0] wrap_q, wrap_d;

   logic [WIDTH-1:0]  nb;
   logic [WIDTH-1:0]  bin_inc;
   logic [WIDTH-1:0]  bin_dec;

   gray_to_bin #(
      .WIDTH (WIDTH)
   ) u_dec (
      .gray_i (GrayIn),
      .bin_o  (nb)
   );

   assign bin_inc = bin_q + 1'b1;
   assign bin_dec = bin_q - 1'b1;

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      gray_d  = gray_q;
      err_d   = 1'b0;
      ovf_d   = ovf_q;
      wrap_d  = wrap_q;
      if (Valid) begin
         unique case (state_q)
            ST_IDLE, ST_FAULT: begin
               gray_d  = GrayIn;
               bin_d   = nb;
               state_d = ST_TRACK;
            end
            ST_TRACK: begin
               // A repeated code is a held count, not a step.
               if (GrayIn == gray_q) begin
                  state_d = ST_TRACK;
               end else if (nb == bin_inc) begin
                  bin_d  = nb;
                  gray_d = GrayIn;
                  if (bin_q == MaxCode && nb == '0) begin
                     wrap_d = wrap_q + 1'b1;
                     ovf_d  = 1'b1;
                  end
`ifdef GRAY_DECODER_DOWN_EN
               end else if (nb == bin_dec) begin
                  bin_d  = nb;
                  gray_d = GrayIn;
                  if (bin_q == '0 && nb == MaxCode) begin
                     wrap_d = wrap_q - 1'b1;
                  end
`endif
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_FAULT;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         bin_q   <= '0;
         gray_q  <= '0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
         wrap_q  <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         gray_q  <= gray_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
         wrap_q  <= wrap_d;
      end
   end

   assign Binary   = bin_q;
   assign Locked   = (state_q == ST_TRACK);
   assign StepErr  = err_q;
   assign Overflow = ovf_q;
   assign WrapCnt  = wrap_q;

   // Only meaningful in the down-count build.
   logic unused_dec;
   assign unused_dec = ^bin_dec;

endmodule

// File: tb/tb_gray_decoder.sv
// Directed bench for gray_decoder with a reference model and scoreboard.
// Expectations follow GRAY_DECODER_DOWN_EN when it is defined.
module tb_gray_decoder;

   localparam int W  = 3;
   localparam int WW = 4;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          Valid;
   logic [W-1:0]  GrayIn;
   logic [W-1:0]  Binary;
   logic          Locked;
   logic          StepErr;
   logic          Overflow;
   logic [WW-1:0] WrapCnt;

   always #5 Clk = ~Clk;

   gray_decoder #(
      .WIDTH  (W),
      .WRAP_W (WW)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Valid    (Valid),
      .GrayIn   (GrayIn),
      .Binary   (Binary),
      .Locked   (Locked),
      .StepErr  (StepErr),
      .Overflow (Overflow),
      .WrapCnt  (WrapCnt)
   );

   typedef struct {
      logic [W-1:0]  bin;
      logic          lock;
      logic          err;
      logic          ovf;
      logic [WW-1:0] wrap;
   } exp_t;

   exp_t sb[$];

   int            checks   = 0;
   int            failures = 0;

   int            m_st;
   logic [W-1:0]  m_bin;
   logic [W-1:0]  m_gray;
   logic          m_ovf;
   logic [WW-1:0] m_wrap;

   logic [W-1:0]  gseq [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                               3'b110, 3'b111, 3'b101, 3'b100};

   function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
      logic [W-1:0] b;
      b = g;
      for (int s = 1; s < W; s++) b = b ^ (g >> s);
      return b;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic v, input logic [W-1:0] g);
      exp_t         e;
      logic [W-1:0] nb;
      @(negedge Clk);
      Reset  = r;
      Valid  = v;
      GrayIn = g;
      nb     = g2b(g);
      e.err  = 1'b0;
      if (r) begin
         m_st = 0; m_bin = '0; m_gray = '0; m_ovf = 1'b0; m_wrap = '0;
      end else if (v) begin
         if (m_st != 1) begin
            m_gray = g; m_bin = nb; m_st = 1;
         end else if (g == m_gray) begin
            m_st = 1;
         end else if (nb == W'(m_bin + 1)) begin
            if (m_bin == 3'd7 && nb == 3'd0) begin
               m_wrap = m_wrap + 4'd1;
               m_ovf  = 1'b1;
            end
            m_bin = nb; m_gray = g;
`ifdef GRAY_DECODER_DOWN_EN
         end else if (nb == W'(m_bin - 1)) begin
            if (m_bin == 3'd0) m_wrap = m_wrap - 4'd1;
            m_bin = nb; m_gray = g;
`endif
         end else begin
            e.err = 1'b1;
            m_st  = 2;
         end
      end
      e.bin  = m_bin;
      e.lock = (m_st == 1);
      e.ovf  = m_ovf;
      e.wrap = m_wrap;
      sb.push_back(e);
      @(posedge Clk);
      #1;
      e = sb.pop_front();
      chk("bin",  32'(Binary),   32'(e.bin));
      chk("lock", 32'(Locked),   32'(e.lock));
      chk("err",  32'(StepErr),  32'(e.err));
      chk("ovf",  32'(Overflow), 32'(e.ovf));
      chk("wrap", 32'(WrapCnt),  32'(e.wrap));
   endtask

   initial begin
      Reset  = 1'b1;
      Valid  = 1'b0;
      GrayIn = '0;

      // 1: full count with one wrap
      cyc(1'b1, 1'b0, 3'b000);
      chk("rst_bin", 32'(Binary), 32'd0);
      chk("rst_lock", 32'(Locked), 32'd0);
      for (int i = 0; i < 9; i++) begin
         cyc(1'b0, 1'b1, gseq[i % 8]);
         chk("t1_bin", 32'(Binary), 32'(i % 8));
         chk("t1_lock", 32'(Locked), 32'd1);
      end
      chk("t1_ovf", 32'(Overflow), 32'd1);
      chk("t1_wrap", 32'(WrapCnt), 32'd1);

      // 2: illegal jump then resync
      cyc(1'b1, 1'b0, 3'b000);
      cyc(1'b0, 1'b1, 3'b000);
      cyc(1'b0, 1'b1, 3'b001);
      cyc(1'b0, 1'b1, 3'b110);
      chk("t2_err", 32'(StepErr), 32'd1);
      chk("t2_bin", 32'(Binary), 32'd1);
      chk("t2_lock", 32'(Locked), 32'd0);
      cyc(1'b0, 1'b0, 3'b110);
      chk("t2_pulse", 32'(StepErr), 32'd0);
      cyc(1'b0, 1'b1, 3'b110);
      chk("t2_resync", 32'(Binary), 32'd4);
      chk("t2_relock", 32'(Locked), 32'd1);

      // 3: idle cycles and repeated codes
      cyc(1'b1, 1'b0, 3'b000);
      cyc(1'b0, 1'b1, 3'b000);
      cyc(1'b0, 1'b1, 3'b001);
      cyc(1'b0, 1'b1, 3'b011);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b0, W'($urandom_range(7)));
         chk("t3_hold", 32'(Binary), 32'd2);
      end
      cyc(1'b0, 1'b1, 3'b011);
      cyc(1'b0, 1'b1, 3'b011);
      chk("t3_rep_bin", 32'(Binary), 32'd2);
      chk("t3_rep_err", 32'(StepErr), 32'd0);

      // 4: reset beats Valid mid-count
      cyc(1'b1, 1'b0, 3'b000);
      for (int i = 0; i < 14; i++) cyc(1'b0, 1'b1, gseq[i % 8]);
      chk("t4_pre_bin", 32'(Binary), 32'd5);
      chk("t4_pre_ovf", 32'(Overflow), 32'd1);
      cyc(1'b1, 1'b1, gseq[6]);
      chk("t4_bin", 32'(Binary), 32'd0);
      chk("t4_ovf", 32'(Overflow), 32'd0);
      chk("t4_wrap", 32'(WrapCnt), 32'd0);
      chk("t4_lock", 32'(Locked), 32'd0);

      // 5: down step
      cyc(1'b1, 1'b0, 3'b000);
      cyc(1'b0, 1'b1, 3'b000);
      cyc(1'b0, 1'b1, 3'b001);
      cyc(1'b0, 1'b1, 3'b011);
      cyc(1'b0, 1'b1, 3'b001);
`ifdef GRAY_DECODER_DOWN_EN
      chk("t5_bin", 32'(Binary), 32'd1);
      chk("t5_err", 32'(StepErr), 32'd0);
      cyc(1'b0, 1'b1, 3'b000);
      cyc(1'b0, 1'b1, 3'b100);
      chk("t5_dn_bin", 32'(Binary), 32'd7);
      chk("t5_dn_wrap", 32'(WrapCnt), 32'd15);
      chk("t5_dn_ovf", 32'(Overflow), 32'd0);
`else
      chk("t5_err", 32'(StepErr), 32'd1);
      chk("t5_lock", 32'(Locked), 32'd0);
      chk("t5_bin", 32'(Binary), 32'd2);
      cyc(1'b0, 1'b1, 3'b000);
      cyc(1'b0, 1'b1, 3'b100);
      chk("t5_dn_err", 32'(StepErr), 32'd1);
      chk("t5_dn_wrap", 32'(WrapCnt), 32'd0);
`endif

      // 6: wrap counter rolls over
      cyc(1'b1, 1'b0, 3'b000);
      cyc(1'b0, 1'b1, 3'b000);
      for (int i = 0; i < 17 * 8; i++) cyc(1'b0, 1'b1, gseq[(i + 1) % 8]);
      chk("t6_wrap", 32'(WrapCnt), 32'd1);
      chk("t6_ovf", 32'(Overflow), 32'd1);
      chk("t6_bin", 32'(Binary), 32'd0);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
